// File: rtl/obstacle_engine.sv
// obstacle_engine: per-frame game state for the obstacle game.
// Ports: clk/reset, frame_tick/start/jump pulses in; obstacle slots,
// player height, run/over status and score/frame pulses out.
module obstacle_engine #(
  parameter int          H_RES     = 640,
  parameter int          NUM_OBS   = 4,
  parameter int          OBS_W     = 16,
  parameter int          OBS_H     = 32,
  parameter int          PLAYER_X  = 64,
  parameter int          PLAYER_W  = 16,
  parameter int          SPEED     = 4,
  parameter int          JUMP_V    = 12,
  parameter int          MIN_GAP   = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    jump,
  output logic [10*NUM_OBS-1:0]   obs_x,
  output logic [NUM_OBS-1:0]      obs_valid,
  output logic [8:0]              player_h,
  output logic                    running,
  output logic                    game_over,
  output logic                    score_inc,
  output logic                    score_clr,
  output logic                    frame_done
);

  localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_OBS - 1);
  localparam logic [9:0] SPD = 10'(SPEED);
  localparam logic [9:0] SPAWN_X = 10'(H_RES);
  localparam logic [10:0] HIT_HI = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0] HIT_LO = 11'(PLAYER_X);
  localparam logic [10:0] OW = 11'(OBS_W);
  localparam logic [8:0] OH = 9'(OBS_H);
  localparam logic signed [5:0] JV = 6'(JUMP_V);
  localparam logic [7:0] GAP = 8'(MIN_GAP);

  typedef enum logic [2:0] {
    IDLE, RUN, PHYS, MOVE, SPAWN, OVER
  } state_t;

  state_t state_q, state_d;
  logic [9:0] x_q [NUM_OBS];
  logic [9:0] x_d [NUM_OBS];
  logic [NUM_OBS-1:0] val_q, val_d;
  logic [8:0] h_q, h_d;
  logic signed [5:0] vel_q, vel_d, v_eff;
  logic signed [10:0] sum;
  logic [9:0] nx;
  logic [10:0] nx11;
  logic jreq_q, jreq_d;
  logic hit_q, hit_d;
  logic inc_q, inc_d;
  logic done_q, done_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic run, found;

  assign run = state_q inside {RUN, PHYS, MOVE, SPAWN};

  always_comb begin
    state_d = state_q;
    x_d = x_q;
    val_d = val_q;
    h_d = h_q;
    vel_d = vel_q;
    jreq_d = jreq_q;
    hit_d = hit_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    inc_d = 1'b0;
    done_d = 1'b0;
    score_clr = 1'b0;
    found = 1'b0;
    // Galois form, taps 16/14/13/11, shifting right.
    lfsr_d = lfsr_q;
    if (run) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
    // A jump only launches from the ground; otherwise keep falling.
    v_eff = (h_q == 9'd0 && jreq_q) ? JV : vel_q;
    sum = $signed({2'b00, h_q}) + $signed({{5{v_eff[5]}}, v_eff});
    nx = x_q[idx_q] - SPD;
    nx11 = {1'b0, nx};
    if (run && jump) jreq_d = 1'b1;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = RUN;
          score_clr = 1'b1;
          x_d = '{default: '0};
          val_d = '0;
          h_d = '0;
          vel_d = '0;
          jreq_d = 1'b0;
          hit_d = 1'b0;
          cnt_d = GAP;
        end
      end
      RUN: begin
        if (frame_tick) state_d = PHYS;
      end
      PHYS: begin
        jreq_d = 1'b0;
        idx_d = '0;
        state_d = MOVE;
        if (sum <= 11'sd0) begin
          h_d = '0;
          vel_d = '0;
        end else begin
          h_d = sum[8:0];
          vel_d = v_eff - 6'sd1;
        end
      end
      MOVE: begin
        if (val_q[idx_q]) begin
          if (x_q[idx_q] < SPD) begin
            // Retiring slot scores and is excluded from collision.
            val_d[idx_q] = 1'b0;
            inc_d = 1'b1;
          end else begin
            x_d[idx_q] = nx;
            if (nx11 < HIT_HI && nx11 + OW > HIT_LO && h_q < OH)
              hit_d = 1'b1;
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = SPAWN;
      end
      SPAWN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          for (int i = 0; i < NUM_OBS; i++) begin
            if (!found && !val_q[i]) begin
              found = 1'b1;
              x_d[i] = SPAWN_X;
              val_d[i] = 1'b1;
            end
          end
          // No free slot: stay at zero and retry next frame.
          if (found) cnt_d = GAP + {2'b00, lfsr_q[5:0]};
        end
        state_d = hit_q ? OVER : RUN;
        hit_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '{default: '0};
      val_q <= '0;
      h_q <= '0;
      vel_q <= '0;
      jreq_q <= 1'b0;
      hit_q <= 1'b0;
      inc_q <= 1'b0;
      done_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= GAP;
      lfsr_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      val_q <= val_d;
      h_q <= h_d;
      vel_q <= vel_d;
      jreq_q <= jreq_d;
      hit_q <= hit_d;
      inc_q <= inc_d;
      done_q <= done_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    obs_x = '0;
    for (int i = 0; i < NUM_OBS; i++) obs_x[10*i +: 10] = x_q[i];
  end

  assign obs_valid = val_q;
  assign player_h = h_q;
  assign running = run;
  assign game_over = (state_q == OVER);
  assign score_inc = inc_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: frame-level reference model of the obstacle game
// driven with randomized gaps and jump timing.
module tb_obstacle_engine;

  localparam int N = 4;
  localparam int H_RES = 640;
  localparam int OBS_W = 16;
  localparam int OBS_H = 32;
  localparam int PLAYER_X = 64;
  localparam int PLAYER_W = 16;
  localparam int SPEED = 4;
  localparam int JUMP_V = 12;
  localparam int MIN_GAP = 40;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset, frame_tick, start, jump;
  logic [10*N-1:0] obs_x;
  logic [N-1:0] obs_valid;
  logic [8:0] player_h;
  logic running, game_over, score_inc, score_clr, frame_done;

  obstacle_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .start(start), .jump(jump), .obs_x(obs_x),
    .obs_valid(obs_valid), .player_h(player_h),
    .running(running), .game_over(game_over),
    .score_inc(score_inc), .score_clr(score_clr),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_x [N];
  bit m_val [N];
  int m_h, m_vel, m_cnt;
  bit m_jreq, m_over, m_run;
  logic [15:0] m_lfsr;
  int m_inc_total = 0;
  int obs_inc_total = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_val[i];
    return v;
  endfunction

  function automatic bit near_player();
    for (int i = 0; i < N; i++)
      if (m_val[i] && m_x[i] == 88) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (m_run) m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0;
      m_val[i] = 1'b0;
    end
    m_h = 0;
    m_vel = 0;
    m_cnt = MIN_GAP;
    m_jreq = 1'b0;
    m_over = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      n_chk++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_frame_done: got %b expected 0", frame_done);
      end
      n_chk++;
      if (score_inc !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_score_inc: got %b expected 0", score_inc);
      end
      cyc();
    end
  endtask

  task automatic idle_jump();
    jump = 1'b1;
    if (m_run && !m_over) m_jreq = 1'b1;
    @(negedge clk);
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_frame_done: got %b expected 0", frame_done);
    end
    cyc();
    jump = 1'b0;
  endtask

  task automatic do_frame(input bit jmp, input bit xtick, output int h_seen);
    bit ret [N];
    bit hit, fnd, exp_inc;
    int s;
    frame_tick = 1'b1;
    jump = jmp;
    if (jmp) m_jreq = 1'b1;
    cyc();
    frame_tick = 1'b0;
    jump = 1'b0;
    if (m_h == 0 && m_jreq) m_vel = JUMP_V;
    m_jreq = 1'b0;
    s = m_h + m_vel;
    if (s <= 0) begin
      m_h = 0;
      m_vel = 0;
    end else begin
      m_h = s;
      m_vel = m_vel - 1;
    end
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      ret[i] = 1'b0;
      if (m_val[i]) begin
        if (m_x[i] < SPEED) begin
          m_val[i] = 1'b0;
          ret[i] = 1'b1;
          m_inc_total++;
        end else begin
          m_x[i] = m_x[i] - SPEED;
          if (m_x[i] < PLAYER_X + PLAYER_W && m_x[i] + OBS_W > PLAYER_X &&
              m_h < OBS_H)
            hit = 1'b1;
        end
      end
    end
    h_seen = -1;
    for (int k = 1; k <= 7; k++) begin
      if (xtick && k == 3) frame_tick = 1'b1;
      if (k == 6) begin
        if (m_cnt != 0) begin
          m_cnt--;
        end else begin
          fnd = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (!fnd && !m_val[i]) begin
              fnd = 1'b1;
              m_val[i] = 1'b1;
              m_x[i] = H_RES;
              m_cnt = MIN_GAP + int'(m_lfsr[5:0]);
            end
          end
        end
        m_over = hit;
      end
      @(negedge clk);
      exp_inc = 1'b0;
      if (k >= 3 && k <= 6) exp_inc = ret[k-3];
      n_chk++;
      if (score_inc !== exp_inc) begin
        n_fail++;
        $display("FAIL score_inc k=%0d: got %b expected %b", k, score_inc, exp_inc);
      end
      if (score_inc === 1'b1) obs_inc_total++;
      n_chk++;
      if (frame_done !== (k == 7)) begin
        n_fail++;
        $display("FAIL frame_done k=%0d: got %b expected %b", k, frame_done, k == 7);
      end
      if (k == 7) begin
        h_seen = int'(player_h);
        n_chk++;
        if (player_h !== 9'(m_h)) begin
          n_fail++;
          $display("FAIL player_h: got %0d expected %0d", player_h, m_h);
        end
        n_chk++;
        if (obs_valid !== exp_valid()) begin
          n_fail++;
          $display("FAIL obs_valid: got %b expected %b", obs_valid, exp_valid());
        end
        for (int i = 0; i < N; i++) begin
          if (m_val[i]) begin
            n_chk++;
            if (obs_x[10*i +: 10] !== 10'(m_x[i])) begin
              n_fail++;
              $display("FAIL obs_x[%0d]: got %0d expected %0d", i, obs_x[10*i +: 10], m_x[i]);
            end
          end
        end
        n_chk++;
        if (game_over !== m_over || running !== !m_over) begin
          n_fail++;
          $display("FAIL status: got over=%b run=%b expected over=%b", game_over, running, m_over);
        end
      end
      cyc();
      frame_tick = 1'b0;
      if (k == 6) m_run = !m_over;
    end
  endtask

  task automatic run_frames(input int n, input bit auto_j);
    int hs;
    bit j;
    for (int f = 0; f < n && !m_over; f++) begin
      j = auto_j && m_h == 0 && near_player();
      idle(int'($urandom_range(0, 2)));
      if (j && $urandom_range(0, 1) == 1) begin
        idle_jump();
        do_frame(1'b0, 1'b0, hs);
      end else begin
        do_frame(j, 1'b0, hs);
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    n_chk++;
    if (score_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL score_clr: got %b expected 1", score_clr);
    end
    cyc();
    start = 1'b0;
    model_clear();
    m_run = 1'b1;
    @(negedge clk);
    n_chk++;
    if (running !== 1'b1 || game_over !== 1'b0 || score_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL start_status: got run=%b over=%b clr=%b expected 1 0 0",
               running, game_over, score_clr);
    end
    n_chk++;
    if (obs_valid !== '0 || player_h !== '0) begin
      n_fail++;
      $display("FAIL start_clear: got valid=%b h=%0d expected 0 0", obs_valid, player_h);
    end
    cyc();
  endtask

  task automatic check_zero(input string tag);
    n_chk++;
    if ({running, game_over, score_inc, score_clr, frame_done} !== 5'b0 ||
        obs_valid !== '0 || obs_x !== '0 || player_h !== '0) begin
      n_fail++;
      $display("FAIL %s: got run=%b over=%b inc=%b clr=%b done=%b v=%b x=%h h=%0d expected all 0",
               tag, running, game_over, score_inc, score_clr, frame_done,
               obs_valid, obs_x, player_h);
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    @(negedge clk);
    check_zero("reset_held");
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset_released");
    cyc();
  endtask

  task automatic test_first_spawn();
    int hs;
    for (int f = 1; f <= 42; f++) begin
      idle(int'($urandom_range(0, 2)));
      do_frame(1'b0, 1'b0, hs);
      if (f == 40) begin
        n_chk++;
        if (obs_valid !== 4'b0000) begin
          n_fail++;
          $display("FAIL early_spawn: got %b expected 0000", obs_valid);
        end
      end
      if (f == 41) begin
        n_chk++;
        if (obs_valid[0] !== 1'b1 || obs_x[9:0] !== 10'd640) begin
          n_fail++;
          $display("FAIL spawn41: got v=%b x=%0d expected 1 640", obs_valid[0], obs_x[9:0]);
        end
      end
      if (f == 42) begin
        n_chk++;
        if (obs_x[9:0] !== 10'd636) begin
          n_fail++;
          $display("FAIL move42: got %0d expected 636", obs_x[9:0]);
        end
      end
    end
  endtask

  task automatic test_jump_arc();
    int seq [25];
    int arc [4];
    int pk;
    arc = '{12, 23, 33, 42};
    idle_jump();
    for (int f = 0; f < 25; f++) do_frame(1'b0, 1'b0, seq[f]);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (seq[i] !== arc[i]) begin
        n_fail++;
        $display("FAIL arc[%0d]: got %0d expected %0d", i, seq[i], arc[i]);
      end
    end
    pk = 0;
    for (int f = 0; f < 25; f++) if (seq[f] > pk) pk = seq[f];
    n_chk++;
    if (pk !== 78) begin
      n_fail++;
      $display("FAIL arc_peak: got %0d expected 78", pk);
    end
    n_chk++;
    if (seq[23] !== 12 || seq[24] !== 0) begin
      n_fail++;
      $display("FAIL arc_land: got %0d,%0d expected 12,0", seq[23], seq[24]);
    end
    run_frames(2, 1'b0);
  endtask

  task automatic test_tick_during_move();
    int hs;
    do_frame(1'b0, 1'b1, hs);
    idle(10);
  endtask

  task automatic test_auto_play();
    run_frames(300, 1'b1);
    n_chk++;
    if (obs_inc_total < 1 || obs_inc_total !== m_inc_total) begin
      n_fail++;
      $display("FAIL retire_count: got %0d expected %0d (nonzero)", obs_inc_total, m_inc_total);
    end
    n_chk++;
    if (game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_over: got game_over=%b expected 0", game_over);
    end
  endtask

  task automatic test_game_over();
    run_frames(260, 1'b0);
    n_chk++;
    if (game_over !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL game_over_reached: got over=%b run=%b expected 1 0", game_over, running);
    end
  endtask

  task automatic test_frozen_restart();
    logic [N-1:0] ev;
    ev = exp_valid();
    for (int c = 0; c < 12; c++) begin
      frame_tick = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_chk++;
      if (frame_done !== 1'b0 || score_inc !== 1'b0 || game_over !== 1'b1 ||
          player_h !== 9'(m_h) || obs_valid !== ev) begin
        n_fail++;
        $display("FAIL frozen c=%0d: got done=%b inc=%b over=%b h=%0d v=%b expected 0 0 1 %0d %b",
                 c, frame_done, score_inc, game_over, player_h, obs_valid, m_h, ev);
      end
      cyc();
    end
    frame_tick = 1'b0;
    jump = 1'b0;
    do_start();
    run_frames(45, 1'b1);
  endtask

  task automatic test_reset_mid();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    m_run = 1'b0;
    m_lfsr = SEED;
    model_clear();
    #1;
    check_zero("reset_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_zero("reset_mid_hold");
      cyc();
    end
    reset = 1'b0;
    idle(2);
    do_start();
    run_frames(150, 1'b1);
    n_chk++;
    if (obs_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_respawn: got %b expected 1", obs_valid[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    start = 1'b0;
    jump = 1'b0;
    m_run = 1'b0;
    m_lfsr = SEED;
    model_clear();
    test_reset();
    do_start();
    test_first_spawn();
    test_jump_arc();
    test_tick_during_move();
    test_auto_play();
    test_game_over();
    test_frozen_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
